transform_loader: RTL and testbench

- Write-side counterpart of the line transformer: accepts a stream of (lhs, rhs) ASCII pairs grouped into lines and packs them into the 256x16 character memory.
- Builds the matching pointer-table entry {len, start} for each completed line, so the transformer can later replay any line by index.
- Sits between the host byte-pair source and the write ports of the character memory and the pointer memory.

---
 rtl/transform_loader_if.sv | 48 ++++
 rtl/transform_loader.sv | 159 +++++++++++++++
 tb/tb_transform_loader.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/transform_loader_if.sv
// -----------------------------------------------------------------------------
// transform_loader_if
//
// Purpose: bundles the byte-pair input stream and the two memory write ports
// of the transform loader.
//
// Handshake: the source holds in_valid together with in_lhs/in_rhs/in_last
// stable until it sees in_ready. A beat transfers on every rising clock edge
// where in_valid && in_ready are both 1. in_ready does not depend on
// in_valid. The memory write ports are plain one-cycle strobes with no
// back-pressure.
//
// Signals:
//   in_valid/in_ready  beat handshake
//   in_lhs, in_rhs     source / transformed character
//   in_last            beat is the final pair of its line
//   mem_we/waddr/din   character memory write port, din = {lhs, rhs}
//   ptr_we/waddr/din   pointer memory write port, din = {len, start}
//
// Modports: slave = the loader, master = the byte-pair source / observer.
// -----------------------------------------------------------------------------
interface transform_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_lhs;
  logic [7:0]  in_rhs;
  logic        in_last;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [15:0] mem_din;
  logic        ptr_we;
  logic [7:0]  ptr_waddr;
  logic [15:0] ptr_din;

  modport slave (
    input  in_valid, in_lhs, in_rhs, in_last,
    output in_ready,
    output mem_we, mem_waddr, mem_din,
    output ptr_we, ptr_waddr, ptr_din
  );

  modport master (
    output in_valid, in_lhs, in_rhs, in_last,
    input  in_ready,
    input  mem_we, mem_waddr, mem_din,
    input  ptr_we, ptr_waddr, ptr_din
  );
endinterface

// File: rtl/transform_loader.sv
// -----------------------------------------------------------------------------
// transform_loader
//
// Purpose: packs a stream of (lhs, rhs) character pairs, grouped into lines,
// into the 256x16 character memory and writes one pointer-table entry
// {len, start} per completed line so the line transformer can replay any
// line by index.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-low reset
//   clear        synchronous restart, empties both tables logically
//   bus          transform_loader_if.slave: input stream + memory write ports
//   line_count   number of completed lines written
//   full         no further input accepted
//   overflow     sticky: a line was truncated or a beat was refused in FULL
//   dbg_state_o  current FSM state (0 ACCEPT, 1 PTR, 2 FULL)
//
// All write-port outputs are registered: a beat accepted in cycle N shows up
// as a memory write in cycle N+1; the line's pointer entry follows in N+2.
// -----------------------------------------------------------------------------
module transform_loader #(
  parameter int          MAX_LINES  = 255,
  parameter logic [7:0]  CHAR_LIMIT = 8'hFE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  transform_loader_if.slave   bus,
  output logic [7:0]          line_count,
  output logic                full,
  output logic                overflow,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_PTR    = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  localparam logic [8:0] MAX_LINES_W = 9'(MAX_LINES);

  state_t      state_q;
  logic [7:0]  char_ptr_q;
  logic [7:0]  line_start_q;
  logic [7:0]  cur_len_q;
  logic [7:0]  line_idx_q;
  logic [7:0]  line_count_q;
  logic        full_q;
  logic        overflow_q;
  logic        mem_we_q;
  logic [7:0]  mem_waddr_q;
  logic [15:0] mem_din_q;
  logic        ptr_we_q;
  logic [7:0]  ptr_waddr_q;
  logic [15:0] ptr_din_q;

  logic ready;
  logic accept;
  logic table_last;

  assign ready  = (state_q == ST_ACCEPT) && !clear && !full_q;
  assign accept = bus.in_valid && ready;

  // The entry about to be written is the last slot of the pointer table.
  assign table_last = ({1'b0, line_idx_q} + 9'd1) == MAX_LINES_W;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_ACCEPT;
      char_ptr_q   <= 8'd0;
      line_start_q <= 8'd0;
      cur_len_q    <= 8'd0;
      line_idx_q   <= 8'd0;
      line_count_q <= 8'd0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= 8'd0;
      mem_din_q    <= 16'd0;
      ptr_we_q     <= 1'b0;
      ptr_waddr_q  <= 8'd0;
      ptr_din_q    <= 16'd0;
    end else begin
      // Strobes are single-cycle pulses unless re-armed below.
      mem_we_q <= 1'b0;
      ptr_we_q <= 1'b0;

      if (clear) begin
        // A strobe registered last cycle is already on the outputs this
        // cycle, so it still reaches the memory; nothing new is scheduled.
        state_q      <= ST_ACCEPT;
        char_ptr_q   <= 8'd0;
        line_start_q <= 8'd0;
        cur_len_q    <= 8'd0;
        line_idx_q   <= 8'd0;
        line_count_q <= 8'd0;
        full_q       <= 1'b0;
        overflow_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_ACCEPT: begin
            if (accept) begin
              mem_we_q    <= 1'b1;
              mem_waddr_q <= char_ptr_q;
              mem_din_q   <= {bus.in_lhs, bus.in_rhs};
              char_ptr_q  <= char_ptr_q + 8'd1;
              cur_len_q   <= cur_len_q + 8'd1;
              if (bus.in_last) begin
                state_q <= ST_PTR;
              end else if (char_ptr_q == CHAR_LIMIT) begin
                // Character memory exhausted mid-line: close the line as it
                // stands; char_ptr passing CHAR_LIMIT then forces FULL.
                state_q    <= ST_PTR;
                overflow_q <= 1'b1;
              end
            end
          end

          ST_PTR: begin
            ptr_we_q     <= 1'b1;
            ptr_waddr_q  <= line_idx_q;
            ptr_din_q    <= {cur_len_q, line_start_q};
            line_idx_q   <= line_idx_q + 8'd1;
            line_count_q <= line_count_q + 8'd1;
            line_start_q <= char_ptr_q;
            cur_len_q    <= 8'd0;
            if ((char_ptr_q > CHAR_LIMIT) || table_last) begin
              state_q <= ST_FULL;
              full_q  <= 1'b1;
            end else begin
              state_q <= ST_ACCEPT;
            end
          end

          ST_FULL: begin
            if (bus.in_valid) overflow_q <= 1'b1;
          end

          default: state_q <= ST_ACCEPT;
        endcase
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.ptr_we    = ptr_we_q;
  assign bus.ptr_waddr = ptr_waddr_q;
  assign bus.ptr_din   = ptr_din_q;
  assign line_count    = line_count_q;
  assign full          = full_q;
  assign overflow      = overflow_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_transform_loader.sv
// -----------------------------------------------------------------------------
// tb_transform_loader
//
// Directed bench for transform_loader. dut1 uses the default table size,
// dut2 a two-entry pointer table. One shared driver feeds whichever DUT
// sel selects. Character/pointer writes of dut1 are matched against
// expected queues by a monitor on the falling edge.
// -----------------------------------------------------------------------------
module tb_transform_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic clear;
  always #5 clk = ~clk;

  // ---------------- driver signals ----------------
  logic       sel;
  logic       drv_valid;
  logic       drv_last;
  logic [7:0] drv_lhs;
  logic [7:0] drv_rhs;
  logic       drv_ready;

  transform_loader_if bus1 ();
  transform_loader_if bus2 ();

  assign bus1.in_valid = drv_valid & ~sel;
  assign bus1.in_lhs   = drv_lhs;
  assign bus1.in_rhs   = drv_rhs;
  assign bus1.in_last  = drv_last;
  assign bus2.in_valid = drv_valid & sel;
  assign bus2.in_lhs   = drv_lhs;
  assign bus2.in_rhs   = drv_rhs;
  assign bus2.in_last  = drv_last;
  assign drv_ready     = sel ? bus2.in_ready : bus1.in_ready;

  logic [7:0] lc1, lc2;
  logic       full1, full2, ovf1, ovf2;
  logic [1:0] st1, st2;

  transform_loader dut1 (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus1.slave),
    .line_count(lc1), .full(full1), .overflow(ovf1), .dbg_state_o(st1)
  );

  transform_loader #(.MAX_LINES(2)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus2.slave),
    .line_count(lc2), .full(full2), .overflow(ovf2), .dbg_state_o(st2)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [23:0] mem_exp_q[$];
  logic [23:0] ptr_exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (bus1.mem_we === 1'b1) begin
      total_cnt++;
      assert (bus1.mem_waddr !== 8'hFF) pass_cnt++;
      else $error("FAIL mem_addr_ff: observed %0h expected not ff", bus1.mem_waddr);
      total_cnt++;
      assert (mem_exp_q.size() != 0) pass_cnt++;
      else $error("FAIL mem_unexpected: observed write %0h/%0h expected none", bus1.mem_waddr, bus1.mem_din);
      if (mem_exp_q.size() != 0) check("mem_write", 32'({bus1.mem_waddr, bus1.mem_din}), 32'(mem_exp_q.pop_front()));
    end
    if (bus1.ptr_we === 1'b1) begin
      total_cnt++;
      assert (ptr_exp_q.size() != 0) pass_cnt++;
      else $error("FAIL ptr_unexpected: observed write %0h/%0h expected none", bus1.ptr_waddr, bus1.ptr_din);
      if (ptr_exp_q.size() != 0) check("ptr_write", 32'({bus1.ptr_waddr, bus1.ptr_din}), 32'(ptr_exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one beat for at most max_wait cycles. Returns at 1 ns after the
  // handshake edge (or after the last refused edge on timeout).
  task automatic send(input logic [7:0] l, input logic [7:0] r, input logic last,
                      input int max_wait, output logic ok, output int waits);
    drv_lhs   = l;
    drv_rhs   = r;
    drv_last  = last;
    drv_valid = 1'b1;
    ok        = 1'b0;
    waits     = 0;
    for (int i = 0; i < max_wait; i++) begin
      #1;
      if (drv_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
      tick();
    end
    if (ok) tick();
    drv_valid = 1'b0;
    drv_last  = 1'b0;
  endtask

  task automatic check_queues_empty(input string tag);
    check({tag, "_mem_q_empty"}, 32'(mem_exp_q.size()), 32'd0);
    check({tag, "_ptr_q_empty"}, 32'(ptr_exp_q.size()), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic ok;
  int   w;
  logic all_ok;
  int   exp_w[6] = '{0, 0, 1, 0, 0, 0};

  initial begin
    rst = 1'b0; clear = 1'b0; sel = 1'b0;
    drv_valid = 1'b0; drv_last = 1'b0; drv_lhs = 8'd0; drv_rhs = 8'd0;

    // Reset state
    #2;
    check("rst_mem_we",     32'(bus1.mem_we),    32'd0);
    check("rst_ptr_we",     32'(bus1.ptr_we),    32'd0);
    check("rst_mem_waddr",  32'(bus1.mem_waddr), 32'd0);
    check("rst_mem_din",    32'(bus1.mem_din),   32'd0);
    check("rst_ptr_waddr",  32'(bus1.ptr_waddr), 32'd0);
    check("rst_ptr_din",    32'(bus1.ptr_din),   32'd0);
    check("rst_line_count", 32'(lc1),            32'd0);
    check("rst_full",       32'(full1),          32'd0);
    check("rst_overflow",   32'(ovf1),           32'd0);
    check("rst_state",      32'(st1),            32'd0);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus1.in_ready), 32'd1);

    // Test 1: one line a/A b/B c/C
    mem_exp_q.push_back({8'h00, 16'h6141});
    mem_exp_q.push_back({8'h01, 16'h6242});
    mem_exp_q.push_back({8'h02, 16'h6343});
    ptr_exp_q.push_back({8'h00, 16'h0300});
    send(8'h61, 8'h41, 1'b0, 4, ok, w); check("t1_b0_ok", 32'(ok), 32'd1);
    send(8'h62, 8'h42, 1'b0, 4, ok, w); check("t1_b1_ok", 32'(ok), 32'd1);
    send(8'h63, 8'h43, 1'b1, 4, ok, w); check("t1_b2_ok", 32'(ok), 32'd1);
    check("t1_memwe_n1",   32'(bus1.mem_we),    32'd1);
    check("t1_memaddr_n1", 32'(bus1.mem_waddr), 32'd2);
    check("t1_ready_ptr",  32'(bus1.in_ready),  32'd0);
    check("t1_state_ptr",  32'(st1),            32'd1);
    tick();
    check("t1_ptr_we",     32'(bus1.ptr_we),    32'd1);
    check("t1_ptr_waddr",  32'(bus1.ptr_waddr), 32'd0);
    check("t1_ptr_din",    32'(bus1.ptr_din),   32'h0300);
    check("t1_line_count", 32'(lc1),            32'd1);
    tick();
    check("t1_ptr_pulse",  32'(bus1.ptr_we),    32'd0);
    check("t1_ready_back", 32'(bus1.in_ready),  32'd1);
    check_queues_empty("t1");

    // Test 2: lines of length 2 and 4 offered back to back
    clear = 1'b1;
    #1;
    check("t2_ready_clear", 32'(bus1.in_ready), 32'd0);
    tick();
    clear = 1'b0;
    check("t2_clear_lc", 32'(lc1), 32'd0);
    for (int i = 0; i < 6; i++) mem_exp_q.push_back({8'(i), 8'(8'h30 + i), 8'(8'h40 + i)});
    ptr_exp_q.push_back({8'h00, 16'h0200});
    ptr_exp_q.push_back({8'h01, 16'h0402});
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h30 + i), 8'(8'h40 + i), (i == 1 || i == 5), 4, ok, w);
      check("t2_ok", 32'(ok), 32'd1);
      check("t2_wait", 32'(w), 32'(exp_w[i]));
    end
    check("t2_ready_ptr", 32'(bus1.in_ready), 32'd0);
    tick();
    check("t2_ptr_we",     32'(bus1.ptr_we),    32'd1);
    check("t2_ptr_waddr",  32'(bus1.ptr_waddr), 32'd1);
    check("t2_ptr_din",    32'(bus1.ptr_din),   32'h0402);
    check("t2_line_count", 32'(lc1),            32'd2);
    tick();
    check_queues_empty("t2");

    // Test 3: 256-beat line truncated at the character limit
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 255; i++) mem_exp_q.push_back({8'(i), 8'(i), ~8'(i)});
    ptr_exp_q.push_back({8'h00, 16'hFF00});
    all_ok = 1'b1;
    for (int i = 0; i < 254; i++) begin
      send(8'(i), ~8'(i), 1'b0, 2, ok, w);
      if (!ok || w != 0) all_ok = 1'b0;
    end
    check("t3_stream_full_rate", 32'(all_ok), 32'd1);
    check("t3_ovf_before", 32'(ovf1),  32'd0);
    check("t3_full_before", 32'(full1), 32'd0);
    send(8'hFE, 8'h01, 1'b0, 2, ok, w);
    check("t3_b254_ok",   32'(ok),            32'd1);
    check("t3_ovf_trunc", 32'(ovf1),          32'd1);
    check("t3_ready_ptr", 32'(bus1.in_ready), 32'd0);
    check("t3_state_ptr", 32'(st1),           32'd1);
    check("t3_full_ptr",  32'(full1),         32'd0);
    tick();
    check("t3_ptr_we",    32'(bus1.ptr_we),  32'd1);
    check("t3_ptr_din",   32'(bus1.ptr_din), 32'hFF00);
    check("t3_full",      32'(full1),        32'd1);
    check("t3_state_full", 32'(st1),         32'd2);
    send(8'hFF, 8'h00, 1'b1, 6, ok, w);
    check("t3_b255_refused", 32'(ok),            32'd0);
    check("t3_ovf_hold",     32'(ovf1),          32'd1);
    check("t3_line_count",   32'(lc1),           32'd1);
    check("t3_ready_full",   32'(bus1.in_ready), 32'd0);
    check_queues_empty("t3");

    // Test 4: two-entry pointer table
    sel = 1'b1;
    send(8'h10, 8'h20, 1'b1, 4, ok, w);
    check("t4_l0_ok",      32'(ok),             32'd1);
    check("t4_l0_mem_we",  32'(bus2.mem_we),    32'd1);
    check("t4_l0_maddr",   32'(bus2.mem_waddr), 32'd0);
    check("t4_l0_mdin",    32'(bus2.mem_din),   32'h1020);
    tick();
    check("t4_l0_ptr_we",  32'(bus2.ptr_we),    32'd1);
    check("t4_l0_paddr",   32'(bus2.ptr_waddr), 32'd0);
    check("t4_l0_pdin",    32'(bus2.ptr_din),   32'h0100);
    check("t4_l0_full",    32'(full2),          32'd0);
    send(8'h11, 8'h21, 1'b1, 4, ok, w);
    check("t4_l1_ok",      32'(ok),             32'd1);
    check("t4_l1_wait",    32'(w),              32'd0);
    check("t4_l1_maddr",   32'(bus2.mem_waddr), 32'd1);
    tick();
    check("t4_l1_ptr_we",  32'(bus2.ptr_we),    32'd1);
    check("t4_l1_paddr",   32'(bus2.ptr_waddr), 32'd1);
    check("t4_l1_pdin",    32'(bus2.ptr_din),   32'h0101);
    check("t4_l1_full",    32'(full2),          32'd1);
    check("t4_l1_lc",      32'(lc2),            32'd2);
    check("t4_l1_ovf",     32'(ovf2),           32'd0);
    check("t4_l1_state",   32'(st2),            32'd2);
    send(8'h12, 8'h22, 1'b1, 5, ok, w);
    check("t4_l2_refused", 32'(ok),             32'd0);
    check("t4_l2_ready",   32'(bus2.in_ready),  32'd0);
    check("t4_l2_ovf",     32'(ovf2),           32'd1);
    check("t4_l2_full",    32'(full2),          32'd1);
    check("t4_l2_lc",      32'(lc2),            32'd2);
    sel = 1'b0;

    // Test 5: clear together with a beat mid-line
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_clr_full",  32'(full1), 32'd0);
    check("t5_clr_ovf",   32'(ovf1),  32'd0);
    check("t5_clr_lc",    32'(lc1),   32'd0);
    check("t5_clr_state", 32'(st1),   32'd0);
    for (int i = 0; i < 3; i++) begin
      mem_exp_q.push_back({8'(i), 8'(8'h50 + i), 8'(8'h60 + i)});
      send(8'(8'h50 + i), 8'(8'h60 + i), 1'b0, 4, ok, w);
      check("t5_beat_ok", 32'(ok), 32'd1);
    end
    drv_lhs = 8'h53; drv_rhs = 8'h63; drv_last = 1'b0; drv_valid = 1'b1;
    clear = 1'b1;
    #1;
    check("t5_ready_clear", 32'(bus1.in_ready), 32'd0);
    tick();
    clear = 1'b0;
    drv_valid = 1'b0;
    check("t5_no_mem_we", 32'(bus1.mem_we), 32'd0);
    check("t5_no_ptr_we", 32'(bus1.ptr_we), 32'd0);
    check("t5_lc",        32'(lc1),         32'd0);
    tick();
    check("t5_no_ptr_we2", 32'(bus1.ptr_we), 32'd0);
    mem_exp_q.push_back({8'h00, 16'h7071});
    ptr_exp_q.push_back({8'h00, 16'h0100});
    send(8'h70, 8'h71, 1'b1, 4, ok, w);
    check("t5_new_ok",    32'(ok),             32'd1);
    check("t5_new_maddr", 32'(bus1.mem_waddr), 32'd0);
    tick();
    check("t5_new_ptr_we", 32'(bus1.ptr_we),    32'd1);
    check("t5_new_paddr",  32'(bus1.ptr_waddr), 32'd0);
    check("t5_new_pdin",   32'(bus1.ptr_din),   32'h0100);
    tick();
    check_queues_empty("t5");

    // Test 6: asynchronous reset while in PTR
    mem_exp_q.push_back({8'h01, 16'h8081});
    send(8'h80, 8'h81, 1'b0, 4, ok, w);
    check("t6_b0_ok", 32'(ok), 32'd1);
    send(8'h82, 8'h83, 1'b1, 4, ok, w);
    check("t6_b1_ok",    32'(ok),  32'd1);
    check("t6_in_ptr",   32'(st1), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_mem_we", 32'(bus1.mem_we),    32'd0);
    check("t6_rst_maddr",  32'(bus1.mem_waddr), 32'd0);
    check("t6_rst_mdin",   32'(bus1.mem_din),   32'd0);
    check("t6_rst_ptr_we", 32'(bus1.ptr_we),    32'd0);
    check("t6_rst_lc",     32'(lc1),            32'd0);
    check("t6_rst_state",  32'(st1),            32'd0);
    #2;
    rst = 1'b1;
    tick();
    check("t6_no_ptr_we",  32'(bus1.ptr_we),   32'd0);
    check("t6_ready",      32'(bus1.in_ready), 32'd1);
    check("t6_lc",         32'(lc1),           32'd0);
    tick();
    check_queues_empty("t6");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
